// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared constants, owner state type and grant decode for bus_arbiter
package bus_arbiter_pkg;

   localparam int BUS_MASTER_CH = 4;
   localparam int BUS_OWNER_W   = 2;
   localparam int BUS_ARB_CNT_W = 8;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [BUS_OWNER_W-1:0] {
      OWN0 = 2'h0,
      OWN1 = 2'h1,
      OWN2 = 2'h2,
      OWN3 = 2'h3
   } owner_e;

   // Active-low one-hot grant vector, bit i belongs to master i.
   function automatic logic [BUS_MASTER_CH-1:0] grant_decode(input owner_e owner);
      logic [BUS_MASTER_CH-1:0] grnt;
      grnt        = {BUS_MASTER_CH{DISABLE_}};
      grnt[owner] = ENABLE_;
      return grnt;
   endfunction

endpackage

// File: rtl/bus_arb_next.sv
// rtl/bus_arb_next.sv - rotation search for the nearest requesting master after the current owner
module bus_arb_next
   import bus_arbiter_pkg::*;
(
   input  owner_e                   owner,
   input  logic [BUS_MASTER_CH-1:0] req_n,
   output owner_e                   next_owner,
   output logic                     any_other
);

   logic [BUS_OWNER_W-1:0] idx;

   // Scan farthest to nearest so the nearest requester in rotation order wins.
   always_comb begin
      next_owner = owner;
      any_other  = 1'b0;
      idx        = '0;
      for (int k = BUS_MASTER_CH - 1; k >= 1; k--) begin
         idx = 2'(owner) + 2'(k);
         if (req_n[idx] == ENABLE_) begin
            next_owner = owner_e'(idx);
            any_other  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - 4-master round-robin, park-on-owner bus arbiter
// Optional hold-timeout revocation enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter logic [BUS_ARB_CNT_W-1:0] ARB_TIMEOUT = 8'd255
)(
   input  logic                   clk,
   input  logic                   reset_,
   input  logic                   M0Req_,
   input  logic                   M1Req_,
   input  logic                   M2Req_,
   input  logic                   M3Req_,
   output logic                   M0Grnt_,
   output logic                   M1Grnt_,
   output logic                   M2Grnt_,
   output logic                   M3Grnt_,
   output logic [BUS_OWNER_W-1:0] Owner,
   output logic                   TimeoutErr
);

   logic [BUS_MASTER_CH-1:0] req_n;
   owner_e                   owner_q;
   owner_e                   owner_d;
   owner_e                   search_owner;
   logic                     other_req;
   logic                     owner_req;
   logic                     force_switch;

   assign req_n     = {M3Req_, M2Req_, M1Req_, M0Req_};
   assign owner_req = (req_n[owner_q] == ENABLE_);

   bus_arb_next u_arb_next (
      .owner      (owner_q),
      .req_n      (req_n),
      .next_owner (search_owner),
      .any_other  (other_req)
   );

`ifdef BUS_ARB_TIMEOUT_EN
   logic [BUS_ARB_CNT_W-1:0] hold_cnt_q;
   logic [BUS_ARB_CNT_W-1:0] hold_cnt_d;
   logic                     timeout_err_q;

   assign force_switch = owner_req && other_req && (hold_cnt_q == ARB_TIMEOUT);

   // Counts only contended holding; any handoff or loss of contention restarts it.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if ((owner_d != owner_q) || !other_req)
         hold_cnt_d = '0;
      else if (owner_req && (hold_cnt_q != ARB_TIMEOUT))
         hold_cnt_d = hold_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         hold_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         hold_cnt_q    <= hold_cnt_d;
         timeout_err_q <= force_switch;
      end
   end

   assign TimeoutErr = timeout_err_q;
`else
   assign force_switch = 1'b0;
   assign TimeoutErr   = 1'b0;
`endif

   always_comb begin
      owner_d = owner_q;
      if (other_req && (!owner_req || force_switch))
         owner_d = search_owner;
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         owner_q <= OWN0;
      else
         owner_q <= owner_d;
   end

   assign Owner = owner_q;
   assign {M3Grnt_, M2Grnt_, M1Grnt_, M0Grnt_} = grant_decode(owner_q);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a reference model
module tb_bus_arbiter;

   localparam int TO = 8;

   logic       clk;
   logic       reset_;
   logic [3:0] req;
   logic       M0Grnt_, M1Grnt_, M2Grnt_, M3Grnt_;
   logic [1:0] Owner;
   logic       TimeoutErr;
   logic [3:0] grants;

   int exp_owner;
   int exp_cnt;
   bit exp_terr;
   int total;
   int bad;

   bus_arbiter #(.ARB_TIMEOUT(8'd8)) dut (
      .clk        (clk),
      .reset_     (reset_),
      .M0Req_     (req[0]),
      .M1Req_     (req[1]),
      .M2Req_     (req[2]),
      .M3Req_     (req[3]),
      .M0Grnt_    (M0Grnt_),
      .M1Grnt_    (M1Grnt_),
      .M2Grnt_    (M2Grnt_),
      .M3Grnt_    (M3Grnt_),
      .Owner      (Owner),
      .TimeoutErr (TimeoutErr)
   );

   assign grants = {M3Grnt_, M2Grnt_, M1Grnt_, M0Grnt_};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] exp_grants(input int own);
      logic [3:0] g;
      g      = 4'hF;
      g[own] = 1'b0;
      return g;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_owner = 0;
      exp_cnt   = 0;
      exp_terr  = 0;
   endtask

   // One clock edge of arbitration computed from the rotation rules.
   task automatic model_step();
      bit own_req;
      int cand;
      bit fire;
      int prev;
      own_req = (req[exp_owner] == 1'b0);
      cand    = -1;
      for (int k = 1; k <= 3; k++)
         if (cand < 0 && req[(exp_owner + k) % 4] == 1'b0) cand = (exp_owner + k) % 4;
      fire = 0;
`ifdef BUS_ARB_TIMEOUT_EN
      fire = own_req && (cand >= 0) && (exp_cnt == TO);
`endif
      prev = exp_owner;
      if (cand >= 0 && (!own_req || fire)) exp_owner = cand;
      if (exp_owner != prev || cand < 0) exp_cnt = 0;
      else if (own_req && exp_cnt < TO) exp_cnt++;
      exp_terr = fire;
   endtask

   // Apply requests, check the parked grant combinationally, then check after the edge.
   task automatic cycle(input logic [3:0] r, input int lit_owner, input int lit_terr);
      req = r;
      #1;
      chk("grant_pre_edge", grants, exp_grants(exp_owner));
      @(posedge clk);
      model_step();
      #1;
      chk("owner", Owner, exp_owner);
      chk("grants", grants, exp_grants(exp_owner));
      chk("timeout_err", TimeoutErr, exp_terr);
      if (lit_owner >= 0) chk("owner_directed", Owner, lit_owner);
      if (lit_terr >= 0) chk("terr_directed", TimeoutErr, lit_terr);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      req    = 4'hF;
      reset_ = 1'b0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      chk("reset_owner", Owner, 0);
      chk("reset_grants", grants, 4'b1110);
      chk("reset_terr", TimeoutErr, 0);
      @(negedge clk);
      reset_ = 1'b1;

      for (int i = 0; i < 10; i++) cycle(4'hF, 0, 0);

      // Parked owner requests: grant already present, ownership holds.
      for (int i = 0; i < 5; i++) cycle(4'b1110, 0, 0);

      cycle(4'hF, 0, 0);
      cycle(4'b1011, 2, 0);

      // Round robin, from owner 2 to owner 1 then rotating releases.
      cycle(4'b1101, 1, 0);
      cycle(4'b0000, 1, 0);
      cycle(4'b0010, 2, 0);
      cycle(4'b0110, 3, 0);
      cycle(4'b1110, 0, 0);
      cycle(4'b1101, 1, 0);

      // Asynchronous reset mid-tenure returns the grant to master 0 at once.
      req = 4'b1101;
      #1;
      reset_ = 1'b0;
      #1;
      chk("async_reset_owner", Owner, 0);
      chk("async_reset_grants", grants, 4'b1110);
      @(negedge clk);
      reset_ = 1'b1;
      model_reset();

      // Contended hold by master 0 with master 1 waiting.
`ifdef BUS_ARB_TIMEOUT_EN
      for (int i = 0; i < TO; i++) cycle(4'b1100, 0, 0);
      cycle(4'b1100, 1, 1);
      cycle(4'b1100, 1, 0);
`else
      for (int i = 0; i < 20; i++) cycle(4'b1100, 0, 0);
`endif

      for (int i = 0; i < 400; i++) begin
         logic [3:0] r;
         r = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) r[exp_owner] = 1'b0;
         cycle(r, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Downstream of each CPU bus interface: consumes the active-low bus request `BusReq_` and returns the active-low grant `BusGrnt_`.
- Arbitrates the shared system bus among 4 masters using round-robin with park-on-owner.
- Exports the current owner index so the bus master multiplexer can route address, strobe, R/W and write data.
- Ownership is held until the owner deasserts its request, which happens after its `BusRdy_`-terminated access.

Parameters:
- ARB_TIMEOUT, 8'd255, max consecutive cycles one owner may hold the bus while another master is requesting. Used only with `BUS_ARB_TIMEOUT_EN`.

Ports:
- clk  in  1  system clock; all state on posedge
- reset_  in  1  asynchronous, active-low reset
- M0Req_  in  1  master 0 bus request, active-low
- M1Req_  in  1  master 1 bus request, active-low
- M2Req_  in  1  master 2 bus request, active-low
- M3Req_  in  1  master 3 bus request, active-low
- M0Grnt_  out  1  master 0 grant, active-low
- M1Grnt_  out  1  master 1 grant, active-low
- M2Grnt_  out  1  master 2 grant, active-low
- M3Grnt_  out  1  master 3 grant, active-low
- Owner  out  2  index of current bus owner, drives master mux select
- TimeoutErr  out  1  1-cycle pulse when ownership is forcibly revoked; constant 0 without the feature

Behaviour:
- Reset is asynchronous, active-low; every clocked register updates with the codebase's `#1` delay.
- Reset values:
  - Owner = 2'd0.
  - M0Grnt_ = ENABLE_ (0); M1–M3Grnt_ = DISABLE_ (1).
  - TimeoutErr = 0; hold counter = 0.
- Grants are a combinational decode of the Owner register. Exactly one grant is active at all times, including when idle (bus parked on owner).
- The owner register is the state; there is one state per master: OWN0, OWN1, OWN2, OWN3.
- Transition, evaluated at each posedge:
  - If the current owner's Req_ = ENABLE_, Owner holds.
  - If the current owner's Req_ = DISABLE_, Owner moves to the first master with Req_ = ENABLE_, searching (Owner+1), (Owner+2), (Owner+3) mod 4.
  - If no master is requesting, Owner holds (park).
- Latency:
  - A request to a non-owner is granted after 1 clock edge, provided the owner is idle.
  - A request from the parked owner sees its grant already asserted, i.e. 0 cycles.
- Simultaneous requests with an idle owner: the winner is the nearest in rotation order after the current owner. No master starves; worst-case wait is 3 tenures.
- Owner release and another request in the same cycle: switch at that edge. No dead cycle is inserted.
- Request deasserted before its grant arrives: no effect; the search ignores it at the next edge.
- The new owner drives its address strobe only after it samples its grant, so the mux select is stable one cycle before the strobe.
- Reset mid-tenure: the grant returns to master 0 immediately (asynchronous). Masters are reset by the same `reset_`.

Optional Feature:
- Macro: `BUS_ARB_TIMEOUT_EN`.
- When defined:
  - An 8-bit hold counter increments each cycle the owner's Req_ is asserted while any other master's Req_ is asserted.
  - The counter clears on an owner change or when no other master is requesting; it saturates at ARB_TIMEOUT.
  - When the counter equals ARB_TIMEOUT at a posedge, Owner is forced to the next requesting master in rotation order, the counter clears, and TimeoutErr pulses 1 for one cycle.
- When undefined: no counter is generated, TimeoutErr is tied to 0, and ownership ends only on release.

Decomposition:
- bus.vh gains:
  - BUS_MASTER_CH (4), BUS_OWNER_W (2), BUS_OWNER_BUS ([1:0]).
  - BUS_OWNER_MASTER_0..3 (2'h0..2'h3).
  - BUS_ARB_CNT_BUS ([7:0]).
- Existing ENABLE_/DISABLE_ and reset macros are reused from nettype.vh / global_config.vh.
- One natural sub-module: bus_arb_next. It is a combinational rotation search taking Owner plus the 4 requests and producing the next owner and an any-request flag. It is shared by the release path and the timeout path.

Test Plan:
- Reset: hold reset_=0 for 3 cycles, then release with no requests -> Owner=0, M0Grnt_=0, others 1; state unchanged for 10 cycles.
- Parked owner: M0Req_=0 -> M0Grnt_ already 0 and stays 0; Owner remains 0 while held for 5 cycles.
- Handoff: master 0 idle, M2Req_=0 -> at the next posedge Owner=2, M2Grnt_=0, M0Grnt_=1.
- Round-robin: Owner=1, all four Req_ asserted, then M1Req_ released -> Owner=2. Release 2 -> 3, release 3 -> 0, release 0 -> 1.
- Back-to-back with bus_if: two bus_if instances issuing reads to addresses outside the SPM region, with a slave returning BusRdy_ after 2 cycles -> both reads complete, grants never overlap, RdData is correct for each.
- Timeout (macro defined, ARB_TIMEOUT=8): M0 holds its request and M1 requests -> after 8 counted cycles Owner=1 and TimeoutErr=1 for exactly one cycle. Without the macro, Owner stays 0 indefinitely.
